// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared types, opcodes and default widths for the request arbiter
package axi4lite_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_TIMEOUT    = 255;

    localparam logic REQ_WRITE = 1'b1;
    localparam logic REQ_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi4lite_req_arbiter_if.sv
// rtl/axi4lite_req_arbiter_if.sv - requester and master-side signal bundle of the request arbiter
interface axi4lite_req_arbiter_if
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;

    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  start_write;
    logic                  start_read;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  done;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  read_data, done,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        output start_write, start_read, write_addr, read_addr, wdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output read_data, done,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        input  start_write, start_read, write_addr, read_addr, wdata
    );

endinterface

// File: rtl/axi4lite_rr_grant2.sv
// rtl/axi4lite_rr_grant2.sv - two-way round-robin grant with last-winner register
module axi4lite_rr_grant2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        if (valid0 && (!valid1 || last_grant)) begin
            grant[0] = 1'b1;
        end else if (valid1) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/axi4lite_req_arbiter.sv
// rtl/axi4lite_req_arbiter.sv - round-robin request sequencer in front of the axi4lite master
module axi4lite_req_arbiter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4lite_req_arbiter_if.slave bus
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [1:0]            grant;
    logic                  accept;
    logic                  timeout_hit;

    logic                  op;
    logic                  owner;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            count;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    logic                  ready0;
    logic                  ready1;
    logic                  rsp0;
    logic                  rsp1;
    logic                  start_w;
    logic                  start_r;

    assign accept      = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign timeout_hit = (count == LAST_COUNT);

    axi4lite_rr_grant2 u_grant (
        .clk    (clk),
        .rst    (rst),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        rsp0       = 1'b0;
        rsp1       = 1'b0;
        start_w    = 1'b0;
        start_r    = 1'b0;
        case (state)
            IDLE: begin
                ready0 = grant[0];
                ready1 = grant[1];
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start_w    = (op == REQ_WRITE);
                start_r    = (op == REQ_READ);
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp0       = !owner;
                rsp1       = owner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A done coinciding with the last WAIT cycle completes normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op    <= 1'b0;
            owner <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            count <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant[1];
                        op    <= grant[1] ? bus.req1_write : bus.req0_write;
                        addr  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
                        wdata <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
                    end
                end
                ISSUE: begin
                    count <= '0;
                end
                WAIT: begin
                    count <= count + 8'd1;
                    if (bus.done) begin
                        rdata <= bus.read_data;
                        err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.rsp0_valid  = rsp0;
    assign bus.rsp1_valid  = rsp1;
    assign bus.rsp_rdata   = rdata;
    assign bus.rsp_err     = err;
    assign bus.start_write = start_w;
    assign bus.start_read  = start_r;
    assign bus.write_addr  = addr;
    assign bus.read_addr   = addr;
    assign bus.wdata       = wdata;

endmodule

// File: doc/axi4lite_req_arbiter.md
# axi4lite_req_arbiter

Two-requester round-robin arbiter and transaction sequencer in front of the `axi4lite_master` user interface (start_write/start_read/addr/wdata/read_data/done). It accepts one read or write request at a time from either requester, issues it to the master as a single-cycle start pulse with stable address and data, and waits for `done` or a watchdog timeout. It then returns the read data and an error flag to the requester that owns the transaction.

## Interface
- `ADDR_WIDTH`, 2, register address width; matches the master.
- `DATA_WIDTH`, 8, data width; matches the master.
- `TIMEOUT`, 255, maximum WAIT cycles before aborting; must be ≥2 and fit in 8 bits.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request pending; held until ready.
- `req0_write`, `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  ADDR_WIDTH  target register.
- `req0_wdata`, `req1_wdata`  in  DATA_WIDTH  write data.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  DATA_WIDTH  read data; valid with rsp strobe; shared by both requesters.
- `rsp_err`  out  1  timeout flag; valid with rsp strobe.
- `start_write`, `start_read`  out  1  one-cycle pulse to the master.
- `write_addr`, `read_addr`  out  ADDR_WIDTH  both driven from the captured address.
- `wdata`  out  DATA_WIDTH  captured write data.
- `read_data`  in  DATA_WIDTH  master read result; sampled on `done`.
- `done`  in  1  master completion pulse.

## Operation
- FSM with states IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `reqN_ready` is combinational: it is high only for the granted requester, and only while that requester's valid is high.
  - On the accepting edge, capture `write` into `op`, plus `addr`, `wdata`, and the owner. Move to ISSUE.
- Grant rule:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `last_grant` updates only on acceptance.
- ISSUE:
  - Exactly one cycle.
  - `start_write = op`; `start_read = !op`.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If `done` is high, capture `read_data` into `rsp_rdata`, set `rsp_err = 0`, and go to RESP. For writes the captured read_data is don't-care, but it is still loaded.
  - Else if the counter equals TIMEOUT−1, set `rsp_rdata = 0`, set `rsp_err = 1`, and go to RESP.
  - If `done` and timeout coincide, `done` wins.
- RESP: assert `rspN_valid` for the owner only, for one cycle, then return to IDLE.
- Address, data and op outputs hold their captured values from ISSUE through RESP and keep them in IDLE. Starts are never asserted outside ISSUE.
- `done` arriving in IDLE, ISSUE or RESP is ignored. A late `done` after a timeout is therefore dropped.
- A request that drops valid before it is accepted is not recorded.
- Reset mid-transaction:
  - All state is cleared immediately.
  - No response is produced for the in-flight request.
  - The master is expected to be reset by the same reset.

## Timing
- Reset values: all ready, rsp_valid and start outputs are 0; `rsp_rdata`, `rsp_err`, addresses and `wdata` are 0; `last_grant` is 1; counter is 0.
- Acceptance happens at edge E, where the request is valid in IDLE.
- The start pulse occurs in cycle E+1.
- With `done` first seen in cycle E+1+k (k ≥ 1), `rspN_valid` occurs in cycle E+2+k.
- Minimum request-to-response latency is 3 cycles.
- Throughput: at most one transaction per k+3 cycles. No new request is accepted until the cycle after RESP.
- A timeout response appears TIMEOUT cycles after entering WAIT, plus 1.

## Structure
- Shared package `axi4lite_pkg` holds:
  - the state enum `arb_state_t` (IDLE/ISSUE/WAIT/RESP);
  - the `REQ_WRITE`/`REQ_READ` constants;
  - the default widths.
- Sub-module `axi4lite_rr_grant2` holds the combinational round-robin grant plus the `last_grant` register. Inputs: the two valids and an accept strobe. Output: a one-hot grant.
- The top-level FSM, capture registers and timeout counter stay in `axi4lite_req_arbiter`.

## Test plan
- **Single write:** req0 write, addr=2, wdata=0xA5; master model returns `done` 4 cycles after start → `start_write` high for one cycle, `write_addr`=2, `wdata`=0xA5, then `rsp0_valid` with `rsp_err`=0 and `rsp1_valid` never high.
- **Single read:** req1 read, addr=3; master returns `read_data`=0x3C with `done` → `start_read` pulse, `read_addr`=3, `rsp1_valid` with `rsp_rdata`=0x3C.
- **Simultaneous requests:** both valid and held, with 4 back-to-back pairs → grant order 0,1,0,1, and each owner receives only its own response strobe.
- **Timeout:** `TIMEOUT`=8, master never asserts `done` → `rsp0_valid` with `rsp_err`=1 and `rsp_rdata`=0 nine cycles after start. A `done` injected 2 cycles later is ignored, and the next request completes normally.
- **Coincident done and timeout:** `done` in the last WAIT cycle with `read_data`=0x77 → `rsp_err`=0, `rsp_rdata`=0x77.
- **Reset mid-WAIT:** assert `rst` → all outputs drop to 0 asynchronously and no rsp strobe is produced. After release, req1 and req0 valid together → req0 is granted first.
